c17_lane_array_bist: RTL and testbench
======================================

Name: c17_lane_array_bist

Overview:
Parametrised, registered array of LANES independent copies of the c17 benchmark function. Each lane maps 5 inputs to 2 outputs. The block adds a built-in self-test (BIST) mode: an on-chip LFSR drives pseudo-random patterns into all lanes and a MISR compacts the lane outputs into a signature. It is the reliability-evaluation wrapper for fault-injection and signature-based test campaigns.

Parameters:
LANES, 4, number of c17 lanes (1..16)
PATTERNS, 256, BIST vectors applied per run (1..65535)
SEED, 16'hACE1, LFSR seed loaded at BIST start (must be non-zero)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mode  in  1  0 = functional, 1 = BIST
in_valid  in  1  functional sample strobe
in_data  in  5*LANES  lane k: bits [5k+0..5k+4] = G1..G5
out_valid  out  1  functional result strobe
out_data  out  2*LANES  lane k: bit [2k] = G6, bit [2k+1] = G7
bist_start  in  1  single-cycle start pulse
bist_busy  out  1  BIST run in progress
bist_done  out  1  signature final
signature  out  16  MISR contents

Behaviour:
- Reset: one clock; asynchronous active-low reset rst_n. All registers clear on rst_n low: out_valid=0, out_data=0, bist_busy=0, bist_done=0, signature=0, LFSR=SEED, FSM=IDLE.
- Lane function, per lane:
  - G6 = (G4 & ~(G5 & G2)) | (G5 & G1)
  - G7 = (G4 | G3) & ~(G5 & G2)
- Functional path, two stages: input register, then output register.
  - in_valid at cycle N gives out_valid at N+2.
  - One sample per cycle, no backpressure.
  - out_data holds its value when out_valid is low.
- Functional samples: in_valid is ignored while mode=1. out_valid is forced low while mode=1; out_data still updates internally.
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, shifts once per RUN cycle. Lane k inputs G(j+1) = lfsr[(5k+j) mod 16], for j = 0..4.
- MISR: 16-bit, same polynomial. Input bit i = XOR of all out_data bits b where b mod 16 = i. It updates on every cycle in which a BIST result leaves the output register.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: if bist_start && mode, go to RUN. Load LFSR=SEED, clear MISR, clear pattern counter.
  - RUN: one pattern per cycle. After PATTERNS vectors, go to FLUSH.
  - FLUSH: 2 cycles to drain the pipeline into the MISR, then go to DONE.
  - DONE: bist_done=1, signature frozen. bist_start restarts (goes to RUN). mode=0 goes to IDLE with bist_done cleared and signature held.
- bist_busy=1 in RUN and FLUSH.
- bist_start is ignored in RUN/FLUSH and when mode=0.
- mode dropped during RUN/FLUSH: abort to IDLE next cycle, busy=0, done=0, signature cleared to 0.
- Mode switch and pipeline: in-flight functional samples present when mode rises are discarded. The pipeline is treated as flushed on every mode change.
- Reset asserted mid-run returns to reset values immediately (asynchronous).
- signature is a live MISR view during RUN/FLUSH. It is valid only while bist_done=1.

Optional Feature:
Macro C17_FAULT_INJ_EN.
- Defined: adds ports fault_en (in, 1), fault_lane (in, 4), fault_bit (in, 1: 0=G6, 1=G7), fault_val (in, 1).
  - While fault_en=1, the selected lane output is stuck at fault_val at the output-register input. This applies in both modes.
  - fault_lane >= LANES has no effect.
- Undefined: these ports are absent and there is no logic overhead.

Test Plan:
1. Reset: rst_n low mid-traffic -> all outputs 0 asynchronously. LFSR=SEED is checked after the first BIST cycle.
2. Functional vectors, LANES=4, lanes fed (G1..G5) = 11001, 00110, 00000, 11111 -> out_data lanes (G7G6) = 01, 11, 00, 01, with out_valid exactly 2 cycles after in_valid. Back-to-back 100 random vectors match the model.
3. BIST run, PATTERNS=256:
   - bist_busy high for 258 cycles, then bist_done=1.
   - signature equals the reference model.
   - A second bist_start gives an identical signature.
4. Abort: mode dropped at RUN cycle 50 -> IDLE next cycle, busy=0, done=0, signature=0. bist_start with mode=0 -> no action.
5. Mode interplay: in_valid pulses while mode=1 -> out_valid stays 0. Return to mode=0 -> first out_valid 2 cycles after the next in_valid.
6. With C17_FAULT_INJ_EN: fault lane 2, G7 stuck-at-1, vector 00000 -> out_data[5]=1, all other bits 0. The BIST signature differs from the fault-free run.

Source files
------------

// File: rtl/c17_lane_array_bist_if.sv
// Bus bundle for the c17 lane array: functional sample path plus BIST control/status.
// Fault-injection controls exist only when C17_FAULT_INJ_EN is defined.
interface c17_lane_array_bist_if #(
    parameter int LANES = 4
);
    logic                 mode;
    logic                 in_valid;
    logic [5*LANES-1:0]   in_data;
    logic                 out_valid;
    logic [2*LANES-1:0]   out_data;
    logic                 bist_start;
    logic                 bist_busy;
    logic                 bist_done;
    logic [15:0]          signature;
`ifdef C17_FAULT_INJ_EN
    logic                 fault_en;
    logic [3:0]           fault_lane;
    logic                 fault_bit;
    logic                 fault_val;

    modport master (
        output mode, in_valid, in_data, bist_start, fault_en, fault_lane, fault_bit, fault_val,
        input  out_valid, out_data, bist_busy, bist_done, signature
    );
    modport slave (
        input  mode, in_valid, in_data, bist_start, fault_en, fault_lane, fault_bit, fault_val,
        output out_valid, out_data, bist_busy, bist_done, signature
    );
`else
    modport master (
        output mode, in_valid, in_data, bist_start,
        input  out_valid, out_data, bist_busy, bist_done, signature
    );
    modport slave (
        input  mode, in_valid, in_data, bist_start,
        output out_valid, out_data, bist_busy, bist_done, signature
    );
`endif
endinterface

// File: rtl/c17_lane_array_bist.sv
// Registered array of c17 lanes with LFSR-driven BIST and MISR signature compaction.
// Define C17_FAULT_INJ_EN to add stuck-at fault injection at the output-register input.
module c17_lane_array_bist #(
    parameter int          LANES    = 4,
    parameter int          PATTERNS = 256,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input logic                  clk,
    input logic                  rst_n,
    c17_lane_array_bist_if.slave bus
);
    // state | meaning
    // IDLE  | functional operation, BIST inactive
    // RUN   | one LFSR pattern applied to all lanes per cycle
    // FLUSH | two cycles draining the pipeline into the MISR
    // DONE  | signature final and frozen
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam int IW = 5 * LANES;
    localparam int OW = 2 * LANES;

    state_t        state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [15:0]   misr_q, misr_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          mode_q, mode_d;
    logic [IW-1:0] in_q, in_d;
    logic [OW-1:0] out_q, out_d;
    logic          v1_q, v1_d, v2_q, v2_d;
    logic          bv1_q, bv1_d, bv2_q, bv2_d;

    logic [IW-1:0] pat;
    logic [OW-1:0] res;
    logic [15:0]   fold;
    logic          mode_chg;

    always_comb begin
        pat = '0;
        for (int k = 0; k < LANES; k++)
            for (int j = 0; j < 5; j++)
                pat[5*k+j] = lfsr_q[(5*k+j) % 16];
    end

    always_comb begin
        res = '0;
        for (int k = 0; k < LANES; k++) begin
            res[2*k]   = (in_q[5*k+3] & ~(in_q[5*k+4] & in_q[5*k+1])) | (in_q[5*k+4] & in_q[5*k+0]);
            res[2*k+1] = (in_q[5*k+3] | in_q[5*k+2]) & ~(in_q[5*k+4] & in_q[5*k+1]);
`ifdef C17_FAULT_INJ_EN
            if (bus.fault_en && (bus.fault_lane == 4'(k))) begin
                if (bus.fault_bit) res[2*k+1] = bus.fault_val;
                else               res[2*k]   = bus.fault_val;
            end
`endif
        end
    end

    // Output bits beyond 16 fold back onto the MISR inputs by XOR.
    always_comb begin
        fold = '0;
        for (int b = 0; b < OW; b++)
            fold[b % 16] = fold[b % 16] ^ out_q[b];
    end

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        misr_d   = misr_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        mode_d   = bus.mode;
        mode_chg = bus.mode ^ mode_q;
        v1_d     = bus.in_valid & ~bus.mode;
        in_d     = v1_d ? bus.in_data : in_q;
        v2_d     = v1_q & ~mode_chg;
        out_d    = (v1_q | bv1_q) ? res : out_q;
        bv1_d    = 1'b0;
        bv2_d    = bv1_q;

        if (bv2_q && (state_q == RUN || state_q == FLUSH))
            misr_d = {misr_q[0] ^ misr_q[2] ^ misr_q[3] ^ misr_q[5], misr_q[15:1]} ^ fold;

        case (state_q)
            IDLE, DONE: begin
                if (bus.mode && bus.bist_start) begin
                    state_d = RUN;
                    lfsr_d  = SEED;
                    misr_d  = '0;
                    cnt_d   = 16'(PATTERNS - 1);
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end else if (!bus.mode) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            RUN, FLUSH: begin
                if (!bus.mode) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    misr_d  = '0;
                    bv2_d   = 1'b0;
                end else begin
                    if (state_q == RUN) begin
                        in_d   = pat;
                        bv1_d  = 1'b1;
                        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
                    end
                    if (cnt_q == 16'd0) begin
                        if (state_q == RUN) begin
                            state_d = FLUSH;
                            cnt_d   = 16'd1;
                        end else begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            misr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= 1'b0;
            in_q    <= '0;
            out_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            bv1_q   <= 1'b0;
            bv2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
            in_q    <= in_d;
            out_q   <= out_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            bv1_q   <= bv1_d;
            bv2_q   <= bv2_d;
        end
    end

    assign bus.out_valid = v2_q & ~bus.mode;
    assign bus.out_data  = out_q;
    assign bus.bist_busy = busy_q;
    assign bus.bist_done = done_q;
    assign bus.signature = misr_q;
endmodule

// File: tb/tb_c17_lane_array_bist.sv
// Directed bench for c17_lane_array_bist: functional path, BIST run/abort, mode interplay,
// and (with C17_FAULT_INJ_EN) fault injection.
module tb_c17_lane_array_bist;
    localparam int          LANES = 4;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    c17_lane_array_bist_if #(.LANES(LANES)) bus ();

    c17_lane_array_bist #(.LANES(LANES), .PATTERNS(256), .SEED(SEED)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] c17_ref(logic [4:0] g);
        logic g6, g7;
        g6 = (g[3] & ~(g[4] & g[1])) | (g[4] & g[0]);
        g7 = (g[3] | g[2]) & ~(g[4] & g[1]);
        return {g7, g6};
    endfunction

    function automatic logic [7:0] lanes_ref(logic [19:0] d);
        logic [7:0] o;
        logic [1:0] r;
        o = '0;
        for (int k = 0; k < 4; k++) begin
            r = c17_ref(d[5*k +: 5]);
            o[2*k]   = r[0];
            o[2*k+1] = r[1];
        end
        return o;
    endfunction

    function automatic logic [15:0] bist_ref(int n);
        logic [15:0] s, m;
        logic [7:0]  o;
        s = SEED;
        m = '0;
        for (int p = 0; p < n; p++) begin
            o = lanes_ref({s[3:0], s});
            m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]} ^ {8'h00, o};
            s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_bist(output int cycles);
        bus.bist_start = 1'b1;
        tick();
        bus.bist_start = 1'b0;
        cycles = bus.bist_busy ? 1 : 0;
        for (int i = 0; i < 1000 && bus.bist_busy; i++) begin
            tick();
            if (bus.bist_busy) cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++; if ({bus.out_valid, bus.out_data, bus.bist_busy, bus.bist_done, bus.signature} !== 27'd0) begin
            n_err++; $display("FAIL reset_init: got %h want 0", {bus.out_valid, bus.out_data, bus.bist_busy, bus.bist_done, bus.signature});
        end
        rst_n = 1'b1;
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 20'hFFFFF;
        repeat (3) tick();
        n_cmp++; if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h55}) begin
            n_err++; $display("FAIL reset_pre_traffic: got %b/%h want 1/55", bus.out_valid, bus.out_data);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.out_valid, bus.out_data, bus.bist_busy, bus.bist_done, bus.signature} !== 27'd0) begin
            n_err++; $display("FAIL reset_async: got %h want 0", {bus.out_valid, bus.out_data, bus.bist_busy, bus.bist_done, bus.signature});
        end
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_functional();
        bus.in_valid = 1'b1;
        bus.in_data  = {5'b11111, 5'b00000, 5'b01100, 5'b10011};
        tick();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL func_lat1: out_valid got %b want 0", bus.out_valid);
        end
        tick();
        n_cmp++; if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h4D}) begin
            n_err++; $display("FAIL func_vec: got %b/%h want 1/4d", bus.out_valid, bus.out_data);
        end
        tick();
        n_cmp++; if ({bus.out_valid, bus.out_data} !== {1'b0, 8'h4D}) begin
            n_err++; $display("FAIL func_hold: got %b/%h want 0/4d", bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] vec [100];
        for (int i = 0; i < 100; i++) vec[i] = 20'($urandom);
        for (int i = 0; i < 102; i++) begin
            bus.in_valid = (i < 100);
            bus.in_data  = (i < 100) ? vec[i] : 20'h0;
            tick();
            if (i >= 1 && i <= 100) begin
                n_cmp++; if ({bus.out_valid, bus.out_data} !== {1'b1, lanes_ref(vec[i-1])}) begin
                    n_err++; $display("FAIL b2b[%0d]: got %b/%h want 1/%h", i - 1, bus.out_valid, bus.out_data, lanes_ref(vec[i-1]));
                end
            end
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_bist();
        int          cyc;
        logic [15:0] want;
        want = bist_ref(256);
        bus.mode = 1'b1;
        tick();
        run_bist(cyc);
        n_cmp++; if (cyc !== 258) begin
            n_err++; $display("FAIL bist_busy_len: got %0d want 258", cyc);
        end
        n_cmp++; if ({bus.bist_done, bus.signature} !== {1'b1, want}) begin
            n_err++; $display("FAIL bist_sig1: got %b/%h want 1/%h", bus.bist_done, bus.signature, want);
        end
        tick();
        n_cmp++; if ({bus.bist_done, bus.signature} !== {1'b1, want}) begin
            n_err++; $display("FAIL bist_frozen: got %b/%h want 1/%h", bus.bist_done, bus.signature, want);
        end
        run_bist(cyc);
        n_cmp++; if ({cyc, bus.bist_done, bus.signature} !== {258, 1'b1, want}) begin
            n_err++; $display("FAIL bist_sig2: got %0d/%b/%h want 258/1/%h", cyc, bus.bist_done, bus.signature, want);
        end
        bus.mode = 1'b0;
        tick();
        n_cmp++; if ({bus.bist_done, bus.bist_busy, bus.signature} !== {2'b00, want}) begin
            n_err++; $display("FAIL bist_exit: got %b%b/%h want 00/%h", bus.bist_done, bus.bist_busy, bus.signature, want);
        end
    endtask

    task automatic test_abort();
        logic [15:0] part;
        part = bist_ref(48);
        bus.mode = 1'b1;
        tick();
        bus.bist_start = 1'b1;
        tick();
        bus.bist_start = 1'b0;
        n_cmp++; if ({bus.bist_busy, bus.bist_done} !== 2'b10) begin
            n_err++; $display("FAIL abort_start: busy/done got %b%b want 10", bus.bist_busy, bus.bist_done);
        end
        tick();
        tick();
        n_cmp++; if (bus.out_data !== lanes_ref({SEED[3:0], SEED})) begin
            n_err++; $display("FAIL abort_seed_pattern: got %h want %h", bus.out_data, lanes_ref({SEED[3:0], SEED}));
        end
        repeat (48) tick();
        n_cmp++; if (bus.signature !== part) begin
            n_err++; $display("FAIL abort_live_sig: got %h want %h", bus.signature, part);
        end
        bus.mode = 1'b0;
        tick();
        n_cmp++; if ({bus.bist_busy, bus.bist_done, bus.signature} !== 18'd0) begin
            n_err++; $display("FAIL abort_idle: got %b%b/%h want 00/0000", bus.bist_busy, bus.bist_done, bus.signature);
        end
        bus.bist_start = 1'b1;
        tick();
        bus.bist_start = 1'b0;
        tick();
        n_cmp++; if ({bus.bist_busy, bus.bist_done, bus.out_valid} !== 3'b000) begin
            n_err++; $display("FAIL abort_start_mode0: got %b%b%b want 000", bus.bist_busy, bus.bist_done, bus.out_valid);
        end
    endtask

    task automatic test_mode();
        bus.mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = (i < 3);
            bus.in_data  = 20'($urandom);
            tick();
            n_cmp++; if (bus.out_valid !== 1'b0) begin
                n_err++; $display("FAIL mode1_valid[%0d]: got %b want 0", i, bus.out_valid);
            end
        end
        bus.in_valid = 1'b0;
        bus.mode = 1'b0;
        tick();
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 20'h12345;
        tick();
        bus.in_valid = 1'b0;
        bus.mode = 1'b1;
        tick();
        bus.mode = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL mode_discard: got %b want 0", bus.out_valid);
        end
        tick();
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = {5'b01100, 5'b10011, 5'b11111, 5'b00000};
        tick();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL mode_ret_lat1: got %b want 0", bus.out_valid);
        end
        tick();
        n_cmp++; if ({bus.out_valid, bus.out_data} !== {1'b1, 8'hD4}) begin
            n_err++; $display("FAIL mode_ret_vec: got %b/%h want 1/d4", bus.out_valid, bus.out_data);
        end
    endtask

`ifdef C17_FAULT_INJ_EN
    task automatic test_fault();
        int cyc;
        bus.fault_en   = 1'b1;
        bus.fault_lane = 4'd2;
        bus.fault_bit  = 1'b1;
        bus.fault_val  = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = 20'h0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        n_cmp++; if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h20}) begin
            n_err++; $display("FAIL fault_stuck: got %b/%h want 1/20", bus.out_valid, bus.out_data);
        end
        bus.fault_lane = 4'd5;
        bus.in_valid   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        n_cmp++; if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h00}) begin
            n_err++; $display("FAIL fault_lane_oob: got %b/%h want 1/00", bus.out_valid, bus.out_data);
        end
        bus.fault_lane = 4'd2;
        bus.mode = 1'b1;
        tick();
        run_bist(cyc);
        n_cmp++; if (bus.bist_done !== 1'b1 || bus.signature === bist_ref(256)) begin
            n_err++; $display("FAIL fault_sig: got %b/%h want 1/not %h", bus.bist_done, bus.signature, bist_ref(256));
        end
        bus.mode = 1'b0;
        bus.fault_en = 1'b0;
        tick();
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mode       = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.bist_start = 1'b0;
`ifdef C17_FAULT_INJ_EN
        bus.fault_en   = 1'b0;
        bus.fault_lane = 4'd0;
        bus.fault_bit  = 1'b0;
        bus.fault_val  = 1'b0;
`endif
        test_reset();
        test_functional();
        test_back_to_back();
        test_bist();
        test_abort();
        test_mode();
`ifdef C17_FAULT_INJ_EN
        test_fault();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
